// File: rtl/rsi_multi_channel.sv
// Multi-channel RSI signal block: per-stock sliding window of N price deltas and a 7-cycle
// restoring divider. Define RSI_HYST_EN for edge-triggered buy/sell flags via per-channel zones.
module rsi_multi_channel #(
  parameter int unsigned PRICE_W = 14,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned N       = 10,
  parameter int unsigned RSI_OB  = 70,
  parameter int unsigned RSI_OS  = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_stock_id,
  input  logic [PRICE_W-1:0] in_price,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_stock_id,
  output logic [6:0]         out_rsi,
  output logic               out_warm,
  output logic               buy_signal,
  output logic               sell_signal
);

  localparam int unsigned NUM_CH = 1 << CH_W;
  localparam int unsigned CW     = $clog2(N + 1);
  localparam int unsigned SW     = PRICE_W + CW;
  localparam int unsigned PW     = $clog2(N);
  localparam int unsigned DW     = SW + 7;
  localparam logic [DW-1:0] Hundred = DW'(100);

  typedef enum logic [1:0] {StIdle, StUpdate, StDivide, StDone} state_e;

  state_e state_q, state_d;

  logic [CH_W-1:0]           ch_q;
  logic [PRICE_W-1:0]        price_q;
  logic [PRICE_W-1:0]        prev_q [NUM_CH];
  logic                      seen_q [NUM_CH];
  logic signed [PRICE_W:0]   dmem_q [NUM_CH][N];
  logic [PW-1:0]             wr_q   [NUM_CH];
  logic [CW-1:0]             cnt_q  [NUM_CH];
  logic [SW-1:0]             gain_q [NUM_CH];
  logic [SW-1:0]             loss_q [NUM_CH];
  logic [DW-1:0]             rem_q;
  logic [SW-1:0]             dvs_q;
  logic [6:0]                quo_q;
  logic [2:0]                bit_q;
  logic                      warm_q;

  // Window update for the channel being processed
  logic signed [PRICE_W:0] delta, ndelta, oldest, noldest;
  logic [SW-1:0]           gain_new, loss_new, sum_new;
  logic [CW-1:0]           cnt_new;

  always_comb begin
    delta    = $signed({1'b0, price_q}) - $signed({1'b0, prev_q[ch_q]});
    ndelta   = -delta;
    oldest   = dmem_q[ch_q][wr_q[ch_q]];
    noldest  = -oldest;
    gain_new = gain_q[ch_q];
    loss_new = loss_q[ch_q];
    cnt_new  = cnt_q[ch_q];
    if (seen_q[ch_q]) begin
      if (cnt_q[ch_q] == CW'(N)) begin
        if (oldest > 0)      gain_new = gain_new - SW'($unsigned(oldest));
        else if (oldest < 0) loss_new = loss_new - SW'($unsigned(noldest));
      end else begin
        cnt_new = cnt_q[ch_q] + CW'(1);
      end
      if (delta > 0)      gain_new = gain_new + SW'($unsigned(delta));
      else if (delta < 0) loss_new = loss_new + SW'($unsigned(ndelta));
    end
    sum_new = gain_new + loss_new;
  end

  // One restoring step; quotient < 128 so starting at bit 6 never overflows
  logic [DW-1:0] dvs_sh;
  logic          fits;
  logic [6:0]    quo_step;

  always_comb begin
    dvs_sh   = DW'(dvs_q) << bit_q;
    fits     = rem_q >= dvs_sh;
    quo_step = quo_q;
    if (fits) quo_step[bit_q] = 1'b1;
  end

  logic       load_out;
  logic [6:0] rsi_res;
  logic       warm_res, in_low, in_high, buy_res, sell_res;

  always_comb begin
    load_out = (state_q == StUpdate && sum_new == '0) || (state_q == StDivide && bit_q == 3'd0);
    rsi_res  = (state_q == StUpdate) ? 7'd50 : quo_step;
    warm_res = (state_q == StUpdate) ? (cnt_new == CW'(N)) : warm_q;
    in_low   = rsi_res < 7'(RSI_OS);
    in_high  = rsi_res > 7'(RSI_OB);
  end

`ifdef RSI_HYST_EN
  localparam logic [1:0] ZLow = 2'd0, ZMid = 2'd1, ZHigh = 2'd2;
  logic [1:0] zone_q [NUM_CH];

  always_comb begin
    buy_res  = warm_res && in_low  && (zone_q[ch_q] != ZLow);
    sell_res = warm_res && in_high && (zone_q[ch_q] != ZHigh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) zone_q[c] <= ZMid;
    end else if (load_out && warm_res) begin
      zone_q[ch_q] <= in_low ? ZLow : (in_high ? ZHigh : ZMid);
    end
  end
`else
  always_comb begin
    buy_res  = warm_res && in_low;
    sell_res = warm_res && in_high;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StUpdate;
      StUpdate: state_d = (sum_new == '0) ? StDone : StDivide;
      StDivide: if (bit_q == 3'd0) state_d = StDone;
      StDone:   state_d = StIdle;
    endcase
  end

  assign in_ready  = rst_n && (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ch_q         <= '0;
      price_q      <= '0;
      rem_q        <= '0;
      dvs_q        <= '0;
      quo_q        <= '0;
      bit_q        <= '0;
      warm_q       <= 1'b0;
      out_stock_id <= '0;
      out_rsi      <= '0;
      out_warm     <= 1'b0;
      buy_signal   <= 1'b0;
      sell_signal  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        prev_q[c] <= '0;
        seen_q[c] <= 1'b0;
        wr_q[c]   <= '0;
        cnt_q[c]  <= '0;
        gain_q[c] <= '0;
        loss_q[c] <= '0;
        for (int k = 0; k < N; k++) dmem_q[c][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) begin
        ch_q    <= in_stock_id;
        price_q <= in_price;
      end
      if (state_q == StUpdate) begin
        prev_q[ch_q] <= price_q;
        seen_q[ch_q] <= 1'b1;
        if (seen_q[ch_q]) begin
          dmem_q[ch_q][wr_q[ch_q]] <= delta;
          wr_q[ch_q] <= (wr_q[ch_q] == PW'(N - 1)) ? '0 : wr_q[ch_q] + PW'(1);
        end
        gain_q[ch_q] <= gain_new;
        loss_q[ch_q] <= loss_new;
        cnt_q[ch_q]  <= cnt_new;
        warm_q       <= (cnt_new == CW'(N));
        rem_q        <= DW'(gain_new) * Hundred;
        dvs_q        <= sum_new;
        quo_q        <= '0;
        bit_q        <= 3'd6;
      end
      if (state_q == StDivide) begin
        if (fits) rem_q <= rem_q - dvs_sh;
        quo_q <= quo_step;
        bit_q <= bit_q - 3'd1;
      end
      if (load_out) begin
        out_stock_id <= ch_q;
        out_rsi      <= rsi_res;
        out_warm     <= warm_res;
        buy_signal   <= buy_res;
        sell_signal  <= sell_res;
      end
    end
  end

endmodule

// File: tb/tb_rsi_multi_channel.sv
// Directed self-checking bench for rsi_multi_channel (default parameters).
module tb_rsi_multi_channel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_stock_id = '0;
  logic [13:0] in_price = '0;
  logic        out_valid;
  logic [1:0]  out_stock_id;
  logic [6:0]  out_rsi;
  logic        out_warm, buy_signal, sell_signal;

  rsi_multi_channel dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_stock_id  (in_stock_id),
    .in_price     (in_price),
    .out_valid    (out_valid),
    .out_stock_id (out_stock_id),
    .out_rsi      (out_rsi),
    .out_warm     (out_warm),
    .buy_signal   (buy_signal),
    .sell_signal  (sell_signal)
  );

  always #5 clk = ~clk;

`ifdef RSI_HYST_EN
  localparam bit ExpSell12 = 1'b0;
`else
  localparam bit ExpSell12 = 1'b1;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] r_rsi;
  logic       r_warm, r_buy, r_sell;
  logic [1:0] r_id;
  int         r_lat;

  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  // One transaction; r_lat counts edges from handshake to the edge sampling out_valid
  task automatic send(input logic [1:0] ch, input logic [13:0] p);
    int guard = 0;
    while (!in_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_stock_id = ch;
    in_price = p;
    @(posedge clk);
    #1 in_valid = 1'b0;
    r_lat = 0;
    do begin
      @(negedge clk);
      r_lat++;
    end while (!out_valid && r_lat < 30);
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: ch=%0d price=%0d no out_valid", ch, p);
    end
    r_rsi = out_rsi; r_warm = out_warm; r_buy = buy_signal; r_sell = sell_signal;
    r_id = out_stock_id;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %0b expected 0", in_ready);
    end
    vectors++;
    if ({out_valid, out_stock_id, out_rsi, out_warm, buy_signal, sell_signal} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0",
               {out_valid, out_stock_id, out_rsi, out_warm, buy_signal, sell_signal});
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_reset: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_rising();
    for (int i = 0; i < 11; i++) begin
      send(2'd0, 14'(10 + i));
      if (i == 0) begin
        vectors++;
        if (r_rsi !== 7'd50 || r_lat != 2) begin
          miscompares++;
          $display("FAIL rise_first: rsi=%0d lat=%0d expected rsi=50 lat=2", r_rsi, r_lat);
        end
      end
      if (i < 10) begin
        vectors++;
        if ({r_warm, r_buy, r_sell} !== 3'b000) begin
          miscompares++;
          $display("FAIL rise_warmup%0d: warm/buy/sell=%b expected 000", i, {r_warm, r_buy, r_sell});
        end
      end else begin
        vectors++;
        if (r_rsi !== 7'd100 || {r_warm, r_buy, r_sell} !== 3'b101 || r_id !== 2'd0) begin
          miscompares++;
          $display("FAIL rise_final: rsi=%0d wbs=%b id=%0d expected rsi=100 wbs=101 id=0",
                   r_rsi, {r_warm, r_buy, r_sell}, r_id);
        end
        vectors++;
        if (r_lat != 9) begin
          miscompares++; $display("FAIL rise_latency: got %0d expected 9", r_lat);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL valid_pulse: got %0b expected 0", out_valid);
    end
  endtask

  task automatic test_falling();
    for (int i = 0; i < 11; i++) send(2'd1, 14'(40 - i));
    vectors++;
    if (r_rsi !== 7'd0 || {r_warm, r_buy, r_sell} !== 3'b110 || r_id !== 2'd1) begin
      miscompares++;
      $display("FAIL fall_final: rsi=%0d wbs=%b id=%0d expected rsi=0 wbs=110 id=1",
               r_rsi, {r_warm, r_buy, r_sell}, r_id);
    end
  endtask

  task automatic test_back_to_back();
    int lows;
    int guard;
    @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      guard = 0;
      while (!in_ready && guard < 30) begin
        @(negedge clk);
        guard++;
      end
      in_valid = 1'b1;
      in_stock_id = 2'd2;
      in_price = (k % 2 == 0) ? 14'd20 : 14'd22;
      @(posedge clk);
      lows = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (out_valid) begin
          r_rsi = out_rsi; r_warm = out_warm; r_buy = buy_signal; r_sell = sell_signal;
        end
        if (in_ready) break;
        lows++;
      end
      if (k > 0) begin
        vectors++;
        if (lows != 9) begin
          miscompares++; $display("FAIL b2b_ready_low%0d: got %0d cycles expected 9", k, lows);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (r_rsi !== 7'd50 || {r_warm, r_buy, r_sell} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_final: rsi=%0d wbs=%b expected rsi=50 wbs=100", r_rsi,
               {r_warm, r_buy, r_sell});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 10; i++) send(2'd0, 14'(i));
    send(2'd0, 14'd4);
    vectors++;
    if (r_rsi !== 7'd60 || {r_warm, r_buy, r_sell} !== 3'b100 || r_lat != 9) begin
      miscompares++;
      $display("FAIL wrap: rsi=%0d wbs=%b lat=%0d expected rsi=60 wbs=100 lat=9", r_rsi,
               {r_warm, r_buy, r_sell}, r_lat);
    end
  endtask

  task automatic test_interleave();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(2'd0, 14'(10 + i));
      vectors++;
      if (r_id !== 2'd0) begin
        miscompares++; $display("FAIL ilv_id0_%0d: got %0d expected 0", i, r_id);
      end
      if (i == 10) begin
        vectors++;
        if (r_rsi !== 7'd100 || {r_warm, r_buy, r_sell} !== 3'b101) begin
          miscompares++;
          $display("FAIL ilv_ch0: rsi=%0d wbs=%b expected rsi=100 wbs=101", r_rsi,
                   {r_warm, r_buy, r_sell});
        end
      end
      send(2'd1, 14'(40 - i));
      vectors++;
      if (r_id !== 2'd1) begin
        miscompares++; $display("FAIL ilv_id1_%0d: got %0d expected 1", i, r_id);
      end
      if (i == 0) begin
        vectors++;
        if (r_rsi !== 7'd50 || r_warm !== 1'b0) begin
          miscompares++;
          $display("FAIL ilv_ch1_first: rsi=%0d warm=%0b expected rsi=50 warm=0", r_rsi, r_warm);
        end
      end
      if (i == 10) begin
        vectors++;
        if (r_rsi !== 7'd0 || {r_warm, r_buy, r_sell} !== 3'b110) begin
          miscompares++;
          $display("FAIL ilv_ch1: rsi=%0d wbs=%b expected rsi=0 wbs=110", r_rsi,
                   {r_warm, r_buy, r_sell});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    do_reset();
    send(2'd0, 14'd10);
    send(2'd0, 14'd11);
    @(negedge clk);
    in_valid = 1'b1;
    in_stock_id = 2'd0;
    in_price = 14'd12;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++; $display("FAIL abort_no_valid: got %0d pulses expected 0", pulses);
    end
    send(2'd0, 14'd7);
    vectors++;
    if (r_rsi !== 7'd50 || r_warm !== 1'b0 || r_lat != 2) begin
      miscompares++;
      $display("FAIL after_abort: rsi=%0d warm=%0b lat=%0d expected rsi=50 warm=0 lat=2",
               r_rsi, r_warm, r_lat);
    end
  endtask

  task automatic test_hold_high();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(2'd0, 14'(10 + i));
      if (i == 10) begin
        vectors++;
        if (r_sell !== 1'b1) begin
          miscompares++; $display("FAIL hold_r11_sell: got %0b expected 1", r_sell);
        end
      end
    end
    vectors++;
    if (r_rsi !== 7'd100 || r_sell !== ExpSell12 || r_buy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_r12: rsi=%0d sell=%0b buy=%0b expected rsi=100 sell=%0b buy=0", r_rsi,
               r_sell, r_buy, ExpSell12);
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_back_to_back();
    test_wrap();
    test_interleave();
    test_mid_reset();
    test_hold_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rsi_multi_channel.md
Name: rsi_multi_channel

Overview:
- Parametrised successor to the single-stock RSI signal block. Tracks up to 2^CH_W stocks independently over a sliding window of N price deltas.
- For every accepted sample it computes an integer RSI (0..100) and raises buy/sell flags against programmable thresholds.
- Sits between the tagged price feed and the trade-decision logic.
- Uses a valid/ready input handshake and a multi-cycle iterative divider in place of the combinational divide.

Parameters:
- PRICE_W, 14: price width in bits (unsigned).
- CH_W, 2: stock-id width; NUM_CH = 2^CH_W channels.
- N, 10: RSI window length in deltas (2..64).
- RSI_OB, 70: overbought threshold; sell when RSI > RSI_OB.
- RSI_OS, 30: oversold threshold; buy when RSI < RSI_OS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_stock_id  in  CH_W  channel of the sample.
- in_price  in  PRICE_W  unsigned price.
- out_valid  out  1  one-cycle pulse: result fields valid.
- out_stock_id  out  CH_W  channel of the result.
- out_rsi  out  7  RSI, 0..100.
- out_warm  out  1  channel holds a full window of N deltas.
- buy_signal  out  1  buy flag, qualified by out_valid.
- sell_signal  out  1  sell flag, qualified by out_valid.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears all per-channel state (prev_price, seen flag, delta memory, write pointer, count, gain_sum, loss_sum) and returns the FSM to IDLE.
  - Reset values: in_ready=0 during reset, 1 in the first cycle after; out_valid=0, out_stock_id=0, out_rsi=0, out_warm=0, buy_signal=0, sell_signal=0.
  - Reset mid-operation aborts any in-flight computation; no out_valid is produced for it.
- FSM states: IDLE, UPDATE, DIVIDE, DONE. in_ready=1 only in IDLE. A handshake (in_valid & in_ready) latches id/price and moves to UPDATE.
- UPDATE (1 cycle), for channel c:
  - First sample ever on c: store prev_price and set seen; sums unchanged; delta treated as absent.
  - Otherwise: d = price - prev_price, signed PRICE_W+1 bits.
    - If count == N, first remove the oldest delta at wr_ptr (positive subtracts from gain_sum, negative magnitude subtracts from loss_sum, zero does nothing).
    - Then add d (positive to gain_sum, |negative| to loss_sum), write d at wr_ptr, and advance wr_ptr modulo N (wraps N-1 -> 0).
    - count saturates at N. prev_price <= price.
  - Sums are unsigned, PRICE_W + clog2(N+1) bits; they can never underflow.
- DIVIDE:
  - If gain_sum + loss_sum == 0: RSI = 50, skip straight to DONE.
  - Else restoring division, exactly 7 cycles, one quotient bit per cycle, MSB first: RSI = floor(100*gain_sum / (gain_sum+loss_sum)).
  - No RSI-scale saturation is needed (result is always <= 100).
  - loss=0, gain>0 gives 100; gain=0, loss>0 gives 0.
- DONE (1 cycle):
  - out_valid=1 with out_stock_id, out_rsi, out_warm = (count==N).
  - buy_signal = out_warm & (RSI < RSI_OS); sell_signal = out_warm & (RSI > RSI_OB). The two are never both 1.
  - Return to IDLE. Result fields hold until the next DONE; out_valid is 0 outside DONE.
- Latency: handshake at cycle T, out_valid at T+9 (T+2 for the zero-sum case). Maximum throughput is 1 sample per 10 cycles.
- Channels are fully independent; interleaved ids never share state.
- Every accepted sample produces exactly one result, including first and warm-up samples (out_warm=0, flags 0).

Optional Feature:
- RSI_HYST_EN defined: signals are edge-triggered, using a per-channel 2-bit zone register (LOW/MID/HIGH, reset MID).
  - buy_signal=1 only on entering LOW (RSI < RSI_OS) from MID or HIGH.
  - sell_signal=1 only on entering HIGH (RSI > RSI_OB) from MID or LOW.
  - Remaining in a zone gives 0. The zone register updates only when out_warm=1.
- RSI_HYST_EN undefined: level-triggered flags as described in Behaviour; no zone registers are built.

Test Plan:
1. Reset, then ch0 prices 10,11,...,20 (11 samples): results 1-10 have out_warm=0 and flags 0 (result 1 RSI=50). Result 11: out_rsi=100, out_warm=1, sell_signal=1, buy_signal=0, out_valid exactly 9 cycles after its handshake.
2. ch1 prices 40,39,...,30: result 11 gives out_rsi=0, buy_signal=1.
3. ch2 prices alternating 20,22,20,22,... (11 samples): gain=10, loss=10, out_rsi=50, no flags. Holding in_valid high shows in_ready=0 for 9 cycles after each accept.
4. ch0 prices 0..10, then 4: window is nine +1 and one -6, so gain=9, loss=6, out_rsi=60, no flags. This checks wrap-around removal of the oldest delta.
5. Scenarios 1 and 2 interleaved sample-by-sample on ch0/ch1: each channel matches its standalone results, and out_stock_id tags every result correctly.
6. Drive rst_n low for 1 cycle during DIVIDE: no out_valid follows. Next ch0 sample 7 yields out_rsi=50, out_warm=0. With RSI_HYST_EN, repeating scenario 1 with price 21 gives sell_signal=1 on result 11 and 0 on result 12.
